// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: in-flight destination scoreboard with youngest-producer forwarding and load-use stall; define FLAG_FWD_EN for CPSR forwarding
module fwd_scoreboard #(
  parameter int REGAW = 4,
  parameter int ALUAW = 4,
  parameter int DEPTH = 3,
  parameter int NSRC = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SELW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  issue_valid,
  input  logic [ALUAW-1:0]      issue_alu_opcode,
  input  logic [REGAW-1:0]      issue_dst,
  input  logic                  issue_is_load,
  input  logic [NSRC*REGAW-1:0] issue_src,
  input  logic [NSRC-1:0]       issue_src_used,
  input  logic                  issue_set_flags,
  output logic                  stall,
  output logic [NSRC*SELW-1:0]  fwd_sel,
  output logic [SELW-1:0]       flag_fwd_sel,
  output logic [SELW-1:0]       pending_cnt
);
  localparam logic [ALUAW-1:0] TST = ALUAW'(8);
  localparam logic [ALUAW-1:0] TEQ = ALUAW'(9);
  localparam logic [ALUAW-1:0] CMP = ALUAW'(10);
  localparam logic [ALUAW-1:0] CMN = ALUAW'(11);
  localparam logic [REGAW-1:0] PC = {REGAW{1'b1}};
  logic [DEPTH:1]   v, w, ld;
  logic [REGAW-1:0] d [1:DEPTH];
  logic             push, wr, stall_any, hit_ld;
  logic [SELW-1:0]  sel, nxt_cnt;
  logic [REGAW-1:0] src;
  assign wr = !(issue_alu_opcode inside {TST, TEQ, CMP, CMN});
  assign stall = issue_valid & stall_any;
  assign push = issue_valid & ~stall;
  always_comb begin
    fwd_sel = '0;
    stall_any = 1'b0;
    sel = '0;
    hit_ld = 1'b0;
    src = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel = '0;
      hit_ld = 1'b0;
      src = issue_src[i*REGAW +: REGAW];
      for (int k = DEPTH; k >= 1; k--)
        if (v[k] && w[k] && issue_src_used[i] && d[k] == src && src != PC) begin
          sel = SELW'(k);
          hit_ld = ld[k];
        end
      fwd_sel[i*SELW +: SELW] = sel;
      stall_any = stall_any | (hit_ld && int'(sel) < LOAD_STAGE);
    end
  end
  always_comb begin
    nxt_cnt = SELW'(push);
    for (int k = 1; k < DEPTH; k++) nxt_cnt = nxt_cnt + SELW'(v[k]);
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      v <= '0;
      w <= '0;
      ld <= '0;
      pending_cnt <= '0;
      for (int k = 1; k <= DEPTH; k++) d[k] <= '0;
    end else begin
      for (int k = DEPTH; k > 1; k--) begin
        v[k] <= v[k-1];
        w[k] <= w[k-1];
        ld[k] <= ld[k-1];
        d[k] <= d[k-1];
      end
      v[1] <= push;
      w[1] <= push & wr;
      ld[1] <= push & issue_is_load;
      d[1] <= push ? issue_dst : '0;
      pending_cnt <= nxt_cnt;
    end
  end
`ifdef FLAG_FWD_EN
  logic [DEPTH:1] sf;
  always_ff @(posedge clk) begin
    if (reset || flush) sf <= '0;
    else begin
      for (int k = DEPTH; k > 1; k--) sf[k] <= sf[k-1];
      sf[1] <= push & issue_set_flags;
    end
  end
  always_comb begin
    flag_fwd_sel = '0;
    for (int k = DEPTH; k >= 1; k--) if (v[k] && sf[k]) flag_fwd_sel = SELW'(k);
  end
`else
  logic unused_set_flags;
  assign unused_set_flags = issue_set_flags;
  assign flag_fwd_sel = '0;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;
  localparam int F = `ifdef FLAG_FWD_EN 1 `else 0 `endif;
  logic       clk = 1'b0;
  logic       reset, flush, issue_valid, issue_is_load, issue_set_flags;
  logic [3:0] issue_alu_opcode, issue_dst;
  logic [7:0] issue_src;
  logic [1:0] issue_src_used;
  logic       stall;
  logic [3:0] fwd_sel;
  logic [1:0] flag_fwd_sel, pending_cnt;
  int         checks = 0;
  int         errors = 0;
  typedef struct {
    string name;
    int rst, fl, v, op, dst, ld, s0, s1, used, sf, st, e0, e1, ef, ec;
  } step_t;
  typedef struct {
    string name;
    logic [8:0] exp;
  } exp_t;
  exp_t exp_q[$];
  fwd_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .issue_alu_opcode(issue_alu_opcode), .issue_dst(issue_dst),
    .issue_is_load(issue_is_load), .issue_src(issue_src),
    .issue_src_used(issue_src_used), .issue_set_flags(issue_set_flags),
    .stall(stall), .fwd_sel(fwd_sel), .flag_fwd_sel(flag_fwd_sel),
    .pending_cnt(pending_cnt)
  );
  always #5 clk = ~clk;
  task automatic apply(input step_t s);
    exp_t e;
    reset = 1'(s.rst);
    flush = 1'(s.fl);
    issue_valid = 1'(s.v);
    issue_alu_opcode = 4'(s.op);
    issue_dst = 4'(s.dst);
    issue_is_load = 1'(s.ld);
    issue_src = {4'(s.s1), 4'(s.s0)};
    issue_src_used = 2'(s.used);
    issue_set_flags = 1'(s.sf);
    e.name = s.name;
    e.exp = {1'(s.st), 2'(s.e1), 2'(s.e0), 2'(s.ef), 2'(s.ec)};
    exp_q.push_back(e);
  endtask
  task automatic clear();
    reset = 1'b1;
    flush = 1'b0;
    issue_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    step_t s[5];
    exp_t e;
    logic [8:0] got;
    s = '{
      '{"rst_fill1", 0,0,1,4,1,0,0,0,0,0, 0,0,0,0,0},
      '{"rst_fill2", 0,0,1,4,2,0,0,0,0,0, 0,0,0,0,1},
      '{"rst_fill3", 0,0,1,4,3,0,0,0,0,0, 0,0,0,0,2},
      '{"rst_full",  1,0,1,4,4,0,1,3,3,0, 0,3,1,0,3},
      '{"rst_after", 0,0,1,4,5,0,1,3,3,0, 0,0,0,0,0}
    };
    clear();
    foreach (s[j]) begin
      apply(s[j]);
      #4;
      e = exp_q.pop_front();
      got = {stall, fwd_sel, flag_fwd_sel, pending_cnt};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: stall/sel1/sel0/flag/cnt got %b expected %b", e.name, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_back_to_back();
    step_t s[6];
    exp_t e;
    logic [8:0] got;
    s = '{
      '{"b2b_add",     0,0,1,4,1,0,0,0,0,0, 0,0,0,0,0},
      '{"b2b_sub",     0,0,1,2,2,0,1,3,3,0, 0,1,0,0,1},
      '{"b2b_fill",    0,0,1,4,6,0,0,0,0,0, 0,0,0,0,2},
      '{"b2b_e3",      0,0,1,4,7,0,1,1,3,0, 0,3,3,0,3},
      '{"b2b_retired", 0,0,1,4,8,0,1,2,3,0, 0,0,3,0,3},
      '{"b2b_unused",  0,0,1,4,9,0,7,8,2,0, 0,0,1,0,3}
    };
    clear();
    foreach (s[j]) begin
      apply(s[j]);
      #4;
      e = exp_q.pop_front();
      got = {stall, fwd_sel, flag_fwd_sel, pending_cnt};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: stall/sel1/sel0/flag/cnt got %b expected %b", e.name, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_compare();
    step_t s[8];
    exp_t e;
    logic [8:0] got;
    s = '{
      '{"cmp_add",  0,0,1,4,1,0,0,0,0,0,  0,0,0,0,0},
      '{"cmp_cmp",  0,0,1,10,1,0,1,2,3,0, 0,1,0,0,1},
      '{"cmp_read", 0,0,1,4,4,0,1,1,3,0,  0,2,2,0,2},
      '{"cmp_cmn",  0,0,1,11,4,0,0,0,0,0, 0,0,0,0,3},
      '{"cmn_read", 0,0,1,4,6,0,4,0,1,0,  0,2,0,0,3},
      '{"cmp_tst",  0,0,1,8,4,0,0,0,0,0,  0,0,0,0,3},
      '{"tst_read", 0,0,1,9,4,0,4,0,1,0,  0,0,0,0,3},
      '{"teq_read", 0,0,1,4,7,0,4,0,1,0,  0,0,0,0,3}
    };
    clear();
    foreach (s[j]) begin
      apply(s[j]);
      #4;
      e = exp_q.pop_front();
      got = {stall, fwd_sel, flag_fwd_sel, pending_cnt};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: stall/sel1/sel0/flag/cnt got %b expected %b", e.name, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_load_use();
    step_t s[7];
    exp_t e;
    logic [8:0] got;
    s = '{
      '{"lu_ldr",   0,0,1,4,5,1,0,0,0,0,  0,0,0,0,0},
      '{"lu_stall", 0,0,1,4,6,0,5,3,3,0,  1,1,0,0,1},
      '{"lu_go",    0,0,1,4,6,0,5,3,3,0,  0,2,0,0,1},
      '{"lu_later", 0,0,1,4,7,0,6,5,3,0,  0,1,3,0,2},
      '{"lu_ldr2",  0,0,1,4,9,1,0,0,0,0,  0,0,0,0,2},
      '{"lu_idle",  0,0,0,4,0,0,9,0,1,0,  0,1,0,0,3},
      '{"lu_e2",    0,0,1,4,10,0,9,0,1,0, 0,2,0,0,2}
    };
    clear();
    foreach (s[j]) begin
      apply(s[j]);
      #4;
      e = exp_q.pop_front();
      got = {stall, fwd_sel, flag_fwd_sel, pending_cnt};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: stall/sel1/sel0/flag/cnt got %b expected %b", e.name, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_shadow();
    step_t s[4];
    exp_t e;
    logic [8:0] got;
    s = '{
      '{"sh_r15",  0,0,1,4,15,0,0,0,0,0, 0,0,0,0,0},
      '{"sh_ldr",  0,0,1,4,5,1,0,0,0,0,  0,0,0,0,1},
      '{"sh_mov",  0,0,1,13,5,0,0,0,0,0, 0,0,0,0,2},
      '{"sh_read", 0,0,1,4,6,0,5,15,3,0, 0,1,0,0,3}
    };
    clear();
    foreach (s[j]) begin
      apply(s[j]);
      #4;
      e = exp_q.pop_front();
      got = {stall, fwd_sel, flag_fwd_sel, pending_cnt};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: stall/sel1/sel0/flag/cnt got %b expected %b", e.name, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_flush();
    step_t s[8];
    exp_t e;
    logic [8:0] got;
    s = '{
      '{"fl_fill1", 0,0,1,4,1,0,0,0,0,0, 0,0,0,0,0},
      '{"fl_fill2", 0,0,1,4,2,0,0,0,0,0, 0,0,0,0,1},
      '{"fl_fill3", 0,0,1,4,3,0,0,0,0,0, 0,0,0,0,2},
      '{"fl_flush", 0,1,1,4,4,0,1,0,1,0, 0,3,0,0,3},
      '{"fl_after", 0,0,1,4,5,0,4,1,3,0, 0,0,0,0,0},
      '{"fl_ldr",   0,0,1,4,8,1,0,0,0,0, 0,0,0,0,1},
      '{"fl_stall", 0,1,1,4,9,0,8,0,1,0, 1,1,0,0,2},
      '{"fl_clear", 0,0,1,4,9,0,8,0,1,0, 0,0,0,0,0}
    };
    clear();
    foreach (s[j]) begin
      apply(s[j]);
      #4;
      e = exp_q.pop_front();
      got = {stall, fwd_sel, flag_fwd_sel, pending_cnt};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: stall/sel1/sel0/flag/cnt got %b expected %b", e.name, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_flags();
    step_t s[5];
    exp_t e;
    logic [8:0] got;
    s = '{
      '{"flg_cmp",   0,0,1,10,0,0,1,2,3,1, 0,0,0,0,0},
      '{"flg_beq",   0,0,1,13,0,0,0,0,0,0, 0,0,0,F,1},
      '{"flg_e2",    0,0,0,0,0,0,0,0,0,0,  0,0,0,2*F,2},
      '{"flg_cmp2",  0,0,1,10,0,0,0,0,0,1, 0,0,0,3*F,2},
      '{"flg_young", 0,0,0,0,0,0,0,0,0,0,  0,0,0,F,2}
    };
    clear();
    foreach (s[j]) begin
      apply(s[j]);
      #4;
      e = exp_q.pop_front();
      got = {stall, fwd_sel, flag_fwd_sel, pending_cnt};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: stall/sel1/sel0/flag/cnt got %b expected %b", e.name, got, e.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_alu_opcode = '0;
    issue_dst = '0;
    issue_is_load = 1'b0;
    issue_src = '0;
    issue_src_used = '0;
    issue_set_flags = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_back_to_back();
    test_compare();
    test_load_use();
    test_shadow();
    test_flush();
    test_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the CPU pipeline.
- Keeps a shift-register scoreboard of the destination registers of the last DEPTH issued instructions.
- For each source operand of the instruction at issue, selects the youngest in-flight producer to forward from.
- Generates a load-use stall when the producer's data is not yet available, and inserts a bubble in that case.

Parameters:
- REGAW, 4, register address width (matches `REGAW).
- ALUAW, 4, ALU opcode width (matches `ALUAW).
- DEPTH, 3, number of tracked in-flight stages (entry 1 = youngest, entry DEPTH = oldest); range 1..7.
- NSRC, 2, number of source operands checked per instruction.
- LOAD_STAGE, 2, first entry index at which a load's result can be forwarded; range 1..DEPTH.
- SELW, 2, width of each forward select; must satisfy 2^SELW > DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  invalidates all scoreboard entries at the next edge.
- issue_valid  in  1  an instruction is presented at issue.
- issue_alu_opcode  in  ALUAW  ALU opcode of the issuing instruction.
- issue_dst  in  REGAW  destination register.
- issue_is_load  in  1  the instruction is a load; its result is ready at LOAD_STAGE.
- issue_src  in  NSRC*REGAW  source registers; operand i occupies bits [i*REGAW +: REGAW].
- issue_src_used  in  NSRC  per-operand "operand is actually read" flag.
- issue_set_flags  in  1  the instruction updates CPSR (used only with FLAG_FWD_EN).
- stall  out  1  hold the issue stage this cycle.
- fwd_sel  out  NSRC*SELW  per operand: 0 = register file, k = forward from entry k.
- flag_fwd_sel  out  SELW  CPSR forward source, same encoding as fwd_sel.
- pending_cnt  out  SELW  number of valid scoreboard entries.

Behaviour:
- Scoreboard entry k (k = 1..DEPTH) holds valid, wr, dst, is_load and setf.
- The scoreboard shifts every clk edge: entry k+1 <= entry k. Entry DEPTH is discarded, and that instruction is considered written back to the register file.
- Entry 1 load:
  - If issue_valid & !stall: load {valid=1, wr, dst=issue_dst, is_load, setf}.
  - Otherwise: load a bubble (valid=0, all other fields 0).
- wr = 0 when issue_alu_opcode is TST, TEQ, CMP or CMN; wr = 1 for every other opcode. Compare ops never create a register producer.
- Forward match for operand i at entry k requires all of: valid, wr, issue_src_used[i], dst == src_i, and src_i != 4'hF. The PC is never forwarded.
- fwd_sel_i = smallest k that matches (youngest wins); 0 if no entry matches. Outputs are combinational from the registered scoreboard and the current issue inputs, so forwarding has zero latency.
- stall = issue_valid & (some operand i whose youngest match is entry k with is_load=1 and k < LOAD_STAGE).
  - While stalled, fwd_sel is still driven, but the downstream stage ignores it.
  - After (LOAD_STAGE − k) stall cycles the load reaches LOAD_STAGE; stall drops and fwd_sel = LOAD_STAGE.
- An older load does not cause a stall when a younger non-load producer of the same register shadows it.
- Register-file bypass for the retiring entry is out of scope: the register file writes before it reads.
- reset (synchronous), at the next edge:
  - All entries become valid=0, wr=0, dst=0, is_load=0, setf=0.
  - Consequently stall=0, fwd_sel=0, flag_fwd_sel=0 and pending_cnt=0 from the first cycle after reset.
- reset takes priority over flush; flush takes priority over issue.
- flush at an edge:
  - All entries become invalid, including entry 1; the issuing instruction is dropped.
  - The cycle after a flush, stall=0 and pending_cnt=0.
- pending_cnt = popcount of valid over entries 1..DEPTH, registered alongside the scoreboard. It saturates naturally at DEPTH.
- With DEPTH=1 and LOAD_STAGE=1, no load-use stall can occur.

Optional Feature:
- Macro FLAG_FWD_EN.
- Defined:
  - setf = issue_set_flags is stored per entry. Compare ops are flag producers when they set flags.
  - flag_fwd_sel = youngest k with valid & setf, or 0 if none.
  - A flag-consuming instruction never stalls; flags are produced in the ALU and are always available from entry 1.
- Undefined:
  - No setf storage; issue_set_flags is ignored.
  - flag_fwd_sel is tied to 0.

Test Plan:
- Reset mid-stream: fill 3 entries, assert reset for 1 cycle -> next cycle pending_cnt=0, fwd_sel=0, stall=0.
- Back-to-back ADD r1 then SUB r2 = r1 + r3 (src0=1) -> fwd_sel[0]=1, fwd_sel[1]=0. Two cycles later, a further read of r1 -> fwd_sel=3. A read of r1 at the 4th cycle after the ADD -> 0.
- CMP r1,r2 then ADD r4 = r1 + r1, where r1 was written 2 instructions earlier -> fwd_sel=2 for both operands; the CMP is ignored.
- LDR r5 then ADD using r5 (LOAD_STAGE=2) -> stall=1 for exactly 1 cycle, entry 1 receives a bubble, then stall=0 and fwd_sel=2.
- Shadowing: LDR r5, MOV r5, then a reader of r5 -> no stall, fwd_sel=1. A reader of r15 with r15 in flight -> fwd_sel=0.
- flush with 3 valid entries plus a valid issue -> next cycle pending_cnt=0. With FLAG_FWD_EN: CMP (setf) then BEQ -> flag_fwd_sel=1.
